// File: rtl/entry_capture.sv
// Push-button capture front end for the 8x4 shift buffer: sync, debounce, latch switches, one write per press.
// Optional build macro ENTRY_CAPTURE_ZERO_REJECT_EN: refuse zero-valued captures and pulse reject instead.
module entry_capture #(
    parameter int DATA_W          = 4,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              button_raw,
    input  logic [DATA_W-1:0] switches,
    output logic [DATA_W-1:0] wr_data,
    output logic              write,
    output logic [3:0]        count,
    output logic              full,
    output logic              busy,
    output logic              reject
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        LOAD,
        STROBE,
        WAIT_RELEASE
    } state_t;

    logic              btn_meta_q, btn_s_q;
    logic [DATA_W-1:0] sw_meta_q, sw_s_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              write_q, write_d;
    logic [3:0]        count_q, count_d;
    logic              reject_q, reject_d;

    // Two-flop synchronisers; the FSM only ever looks at the *_s_q copies.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            btn_meta_q <= button_raw;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= switches;
            sw_s_q     <= sw_meta_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_data_q <= '0;
            write_q   <= 1'b0;
            count_q   <= '0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            write_q   <= write_d;
            count_q   <= count_d;
            reject_q  <= reject_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_data_d = wr_data_q;
        write_d   = 1'b0;
        count_d   = count_q;
        reject_d  = 1'b0;
        if (clear) begin
            // Parking in WAIT_RELEASE keeps a held button from retriggering.
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_s_q) begin
                        cnt_d   = '0;
                        state_d = (enable && !full) ? DEBOUNCE : WAIT_RELEASE;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s_q || !enable) begin
                        state_d = IDLE;
                    end else if (cnt_q + 1'b1 == CNT_LAST) begin
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                LOAD: begin
`ifdef ENTRY_CAPTURE_ZERO_REJECT_EN
                    if (sw_s_q == '0) begin
                        reject_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = WAIT_RELEASE;
                    end else begin
                        wr_data_d = sw_s_q;
                        state_d   = STROBE;
                    end
`else
                    wr_data_d = sw_s_q;
                    state_d   = STROBE;
`endif
                end
                STROBE: begin
                    // write is registered, so it rises one cycle after wr_data settles.
                    write_d = 1'b1;
                    if (count_q != DEPTH_C) count_d = count_q + 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (btn_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_data = wr_data_q;
    assign write   = write_q;
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign busy    = (state_q != IDLE);
    assign reject  = reject_q;

endmodule

// File: tb/tb_entry_capture.sv
// Scoreboard bench for entry_capture: presses push expected outputs, a negedge monitor pops and compares.
module tb_entry_capture;

    localparam int DW  = 4;
    localparam int DEP = 8;
    localparam int DC  = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          enable = 1'b1;
    logic          button_raw = 1'b0;
    logic [DW-1:0] switches = '0;
    logic [DW-1:0] wr_data;
    logic          write;
    logic [3:0]    count;
    logic          full;
    logic          busy;
    logic          reject;

    entry_capture #(.DATA_W(DW), .DEPTH(DEP), .DEBOUNCE_CYCLES(DC)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .enable(enable),
        .button_raw(button_raw), .switches(switches), .wr_data(wr_data),
        .write(write), .count(count), .full(full), .busy(busy), .reject(reject)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rej;
        logic [3:0] data;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] m_cnt = '0;
    logic [3:0] m_wr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write or reject pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && (write || reject)) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_pulse", {30'd0, write, reject}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_kind_reject", reject, e.rej);
                check("sb_kind_write", write, !e.rej);
                check("sb_wr_data", wr_data, e.data);
                check("sb_count", count, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        button_raw = v;
        tick(n);
    endtask

    task automatic expect_press(input logic [3:0] v);
        exp_t e;
        if (m_cnt == 4'(DEP)) return;
`ifdef ENTRY_CAPTURE_ZERO_REJECT_EN
        if (v == 4'd0) begin
            e = '{rej: 1'b1, data: m_wr, cnt: m_cnt};
            sbq.push_back(e);
            return;
        end
`endif
        m_cnt = m_cnt + 4'd1;
        m_wr  = v;
        e = '{rej: 1'b0, data: v, cnt: m_cnt};
        sbq.push_back(e);
    endtask

    task automatic press_raw(input logic [3:0] v);
        switches = v;
        tick(2);
        drive(1'b1, 12);
        drive(1'b0, 10);
    endtask

    task automatic press(input logic [3:0] v);
        expect_press(v);
        press_raw(v);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_cnt = '0;
        @(negedge clock);
        check("clear_count", count, 0);
        tick(8);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_write", write, 0);
        check("rst_count", count, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_reject", reject, 0);
        reset_n = 1'b1;
        tick(3);

        // Clean press: write seen after the 8th edge from the raw change (2 sync + 6 latency)
        switches = 4'b1010;
        tick(2);
        expect_press(4'b1010);
        button_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("latency_write_k%0d", k), write, (k == 8) ? 1 : 0);
        end
        tick(4);
        check("clean_wr_data", wr_data, 4'b1010);
        check("clean_count", count, 1);
        check("clean_busy_held", busy, 1);
        drive(1'b0, 10);
        check("idle_after_release", busy, 0);

        // Bouncy press and bouncy release: exactly one write of 0011
        switches = 4'b0011;
        tick(2);
        expect_press(4'b0011);
        drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 1);
        drive(1'b1, 12);
        drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 1);
        drive(1'b0, 12);
        check("bounce_wr_data", wr_data, 4'b0011);
        check("bounce_count", count, 2);

        // Fill to DEPTH, ninth press swallowed
        do_clear();
        for (int v = 1; v <= 9; v++) begin
            press(4'(v));
            if (v == 7) check("full_at_7", full, 0);
            if (v == 8) check("full_at_8", full, 1);
        end
        check("sat_count", count, 8);
        check("sat_full", full, 1);
        check("sat_wr_data", wr_data, 4'b1000);

        // Clear during STROBE with button held
        do_clear();
        press(4'd5);
        check("pre_clr_count", count, 1);
        switches = 4'd6;
        tick(2);
        button_raw = 1'b1;
        tick(7);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_cnt = '0;
        m_wr  = 4'd6;
        @(negedge clock);
        check("clr_strobe_write", write, 0);
        check("clr_strobe_count", count, 0);
        tick(20);
        drive(1'b0, 10);
        check("clr_no_retrigger", count, 0);
        check("clr_wr_data_kept", wr_data, 4'd6);
        press(4'd7);
        check("post_clr_count", count, 1);

        // Zero-valued capture
        press(4'd0);
`ifdef ENTRY_CAPTURE_ZERO_REJECT_EN
        check("zero_count", count, 1);
        check("zero_wr_data", wr_data, 4'd7);
`else
        check("zero_count", count, 2);
        check("zero_wr_data", wr_data, 4'd0);
`endif

        // Disabled capture is swallowed
        enable = 1'b0;
        press_raw(4'd3);
        enable = 1'b1;
        check("disabled_count", count, m_cnt);

        // Async reset while write is high
        switches = 4'd9;
        tick(2);
        button_raw = 1'b1;
        tick(8);
        check("pre_reset_write", write, 1);
        reset_n    = 1'b0;
        button_raw = 1'b0;
        #1;
        check("async_write", write, 0);
        check("async_count", count, 0);
        check("async_wr_data", wr_data, 0);
        check("async_busy", busy, 0);
        tick(2);
        reset_n = 1'b1;
        tick(5);

        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
